mem_axi_bridge: RTL
===================

MEM_AXI_BRIDGE -- requirements
Module: mem_axi_bridge

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: response-wait limit in cycles; used only when BUS_TIMEOUT_EN is defined.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clk  in  1  clock; all logic on the rising edge.
REQ-004 rstn  in  1  asynchronous active-low reset.
REQ-005 request_enable  in  1  one-cycle request pulse from the memory stage.
REQ-006 mode  in  1  MEMREQ_READ / MEMREQ_WRITE, from the shared package.
REQ-007 addr  in  32  byte address, passed through unmodified.
REQ-008 wdata  in  32  write data.
REQ-009 wstrb  in  4  byte-lane write strobes.
REQ-010 response_enable  out  1  one-cycle completion pulse to the memory stage.
REQ-011 data  out  32  read data, valid with response_enable.
REQ-012 error  out  1  response was not OKAY or timed out; valid with response_enable.
REQ-013 axi_awaddr[32], axi_awprot[3], axi_awvalid out; axi_awready in.
REQ-014 axi_wdata[32], axi_wstrb[4], axi_wvalid out; axi_wready in.
REQ-015 axi_bresp[2], axi_bvalid in; axi_bready out.
REQ-016 axi_araddr[32], axi_arprot[3], axi_arvalid out; axi_arready in.
REQ-017 axi_rdata[32], axi_rresp[2], axi_rvalid in; axi_rready out.

Function
REQ-018 FSM states: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, FLUSH.
REQ-019 request_enable is sampled only in IDLE; mode, addr, wdata and wstrb are latched on that edge; pulses in any other state are ignored.
REQ-020 Write path: IDLE->WR_REQ; axi_awvalid and axi_wvalid rise together; each falls independently after its own handshake; WR_REQ->WR_RESP when both handshakes are done, including the same cycle.
REQ-021 WR_RESP: axi_bready=1; on the axi_bvalid handshake, response_enable=1 the next cycle with data=0 and error=(bresp!=OKAY); state returns to IDLE.
REQ-022 Read path: IDLE->RD_REQ with axi_arvalid=1 until axi_arready, then RD_RESP with axi_rready=1; on axi_rvalid, rdata is captured into data and error=(rresp!=OKAY); response_enable pulses the next cycle; state returns to IDLE.
REQ-023 Minimum latency is 3 cycles from the request_enable edge to response_enable when ready/valid return immediately.
REQ-024 A valid, once asserted, is held with stable address, data and strobes until its handshake.
REQ-025 axi_awprot and axi_arprot are 3'b000.
REQ-026 response_enable is high exactly one cycle per accepted request; data and error hold until the next response.
REQ-027 A request_enable coinciding with the response_enable cycle is accepted (back-to-back operation).
REQ-028 All other handshake outputs are 0 whenever their state is not active.

Reset
REQ-029 rstn=0 asynchronously forces IDLE and sets every output to 0: all valids, readies, response_enable, data, error, addresses, wdata and strobes.
REQ-030 Reset mid-transaction abandons it and produces no response; behaviour after rstn rises is identical to power-up.

Configuration
REQ-031 With BUS_TIMEOUT_EN defined, a counter runs in WR_RESP and RD_RESP; it clears on state entry and on each new request.
REQ-032 When the counter reaches TIMEOUT_CYCLES: response_enable=1, error=1, data=0; state goes to FLUSH, which holds bready/rready=1 until the late response arrives, discards it, and then returns to IDLE; requests are ignored in FLUSH.
REQ-033 Without BUS_TIMEOUT_EN, the counter and FLUSH state are not synthesised and the block waits indefinitely.

Structure
REQ-034 The shared package holds MEMREQ_READ/MEMREQ_WRITE, the AXI response constants (OKAY=2'b00, SLVERR=2'b10) and the FSM state enum type.
REQ-035 Single module; no sub-module is needed.

Verification
REQ-036 Read addr=0x0000_1000, arready=1, rvalid next cycle with rdata=0xDEAD_BEEF, rresp=OKAY -> araddr=0x1000; response_enable 3 cycles after request; data=0xDEADBEEF; error=0.
REQ-037 Write addr=0x20, wdata=0x1234_5678, wstrb=4'b0011; awready 2 cycles before wready -> awvalid and wvalid drop independently; exactly one bready handshake; one response_enable pulse; error=0.
REQ-038 Read with rresp=SLVERR -> error=1 with response_enable; next request has error=0.
REQ-039 Second request_enable while in RD_REQ -> ignored; exactly one AR handshake and one response.
REQ-040 BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8, bvalid withheld 20 cycles -> response_enable with error=1 at count 8; FLUSH consumes the late B; a new request in FLUSH is ignored; IDLE afterwards.
REQ-041 rstn pulsed low while in WR_REQ -> all valids 0 in the same cycle; no response_enable; a following read completes normally.

Source files
------------

// File: rtl/mem_axi_bridge_pkg.sv
// Shared definitions for the memory-stage to AXI4-Lite bridge: request modes,
// AXI response codes and the bridge FSM state type.
package mem_axi_bridge_pkg;

  localparam logic MEMREQ_READ  = 1'b0;
  localparam logic MEMREQ_WRITE = 1'b1;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    WR_REQ,
    WR_RESP,
    RD_REQ,
    RD_RESP,
    FLUSH
  } state_t;

endpackage

// File: rtl/mem_axi_bridge_if.sv
// Bundle of memory-stage request/response signals and the AXI4-Lite master bus.
// The bridge uses the master modport; the memory stage / AXI slave side uses slave.
interface mem_axi_bridge_if;

  logic        request_enable;
  logic        mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        response_enable;
  logic [31:0] data;
  logic        error;

  logic [31:0] axi_awaddr;
  logic [2:0]  axi_awprot;
  logic        axi_awvalid;
  logic        axi_awready;
  logic [31:0] axi_wdata;
  logic [3:0]  axi_wstrb;
  logic        axi_wvalid;
  logic        axi_wready;
  logic [1:0]  axi_bresp;
  logic        axi_bvalid;
  logic        axi_bready;
  logic [31:0] axi_araddr;
  logic [2:0]  axi_arprot;
  logic        axi_arvalid;
  logic        axi_arready;
  logic [31:0] axi_rdata;
  logic [1:0]  axi_rresp;
  logic        axi_rvalid;
  logic        axi_rready;

  modport master (
    input  request_enable, mode, addr, wdata, wstrb,
    output response_enable, data, error,
    output axi_awaddr, axi_awprot, axi_awvalid,
    input  axi_awready,
    output axi_wdata, axi_wstrb, axi_wvalid,
    input  axi_wready,
    input  axi_bresp, axi_bvalid,
    output axi_bready,
    output axi_araddr, axi_arprot, axi_arvalid,
    input  axi_arready,
    input  axi_rdata, axi_rresp, axi_rvalid,
    output axi_rready
  );

  modport slave (
    output request_enable, mode, addr, wdata, wstrb,
    input  response_enable, data, error,
    input  axi_awaddr, axi_awprot, axi_awvalid,
    output axi_awready,
    input  axi_wdata, axi_wstrb, axi_wvalid,
    output axi_wready,
    output axi_bresp, axi_bvalid,
    input  axi_bready,
    input  axi_araddr, axi_arprot, axi_arvalid,
    output axi_arready,
    output axi_rdata, axi_rresp, axi_rvalid,
    input  axi_rready
  );

endinterface

// File: rtl/mem_axi_bridge.sv
// Single-outstanding bridge from a memory-stage request pulse to an AXI4-Lite master.
// Define BUS_TIMEOUT_EN to add a response timeout that answers with error and drains via FLUSH.
module mem_axi_bridge
  import mem_axi_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rstn,
  mem_axi_bridge_if.master bus
);

  state_t      r_state;
  logic        r_awvalid;
  logic        r_wvalid;
  logic        r_bready;
  logic        r_arvalid;
  logic        r_rready;
  logic [31:0] r_awaddr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic [31:0] r_araddr;
  logic        r_rsp_en;
  logic [31:0] r_data;
  logic        r_error;

  logic        w_aw_done;
  logic        w_w_done;
  logic        w_tmo_hit;

  // A channel counts as done if its handshake already happened or happens this cycle.
  assign w_aw_done = !r_awvalid || bus.axi_awready;
  assign w_w_done  = !r_wvalid  || bus.axi_wready;

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] r_tmo_cnt;

  // Counts cycles spent waiting for B/R; any other state holds it at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_tmo_cnt <= '0;
    end else if (r_state == WR_RESP || r_state == RD_RESP) begin
      r_tmo_cnt <= r_tmo_cnt + 1'b1;
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign w_tmo_hit = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  logic w_unused_tmo;
  assign w_unused_tmo = (TIMEOUT_CYCLES != 0);
  assign w_tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state   <= IDLE;
      r_awvalid <= 1'b0;
      r_wvalid  <= 1'b0;
      r_bready  <= 1'b0;
      r_arvalid <= 1'b0;
      r_rready  <= 1'b0;
      r_awaddr  <= '0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_araddr  <= '0;
      r_rsp_en  <= 1'b0;
      r_data    <= '0;
      r_error   <= 1'b0;
    end else begin
      r_rsp_en <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.request_enable) begin
            if (bus.mode == MEMREQ_WRITE) begin
              r_awaddr  <= bus.addr;
              r_wdata   <= bus.wdata;
              r_wstrb   <= bus.wstrb;
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_state   <= WR_REQ;
            end else begin
              r_araddr  <= bus.addr;
              r_arvalid <= 1'b1;
              r_state   <= RD_REQ;
            end
          end
        end
        WR_REQ: begin
          if (bus.axi_awready) r_awvalid <= 1'b0;
          if (bus.axi_wready)  r_wvalid  <= 1'b0;
          if (w_aw_done && w_w_done) begin
            r_bready <= 1'b1;
            r_state  <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bus.axi_bvalid) begin
            r_bready <= 1'b0;
            r_rsp_en <= 1'b1;
            r_data   <= '0;
            r_error  <= (bus.axi_bresp != OKAY);
            r_state  <= IDLE;
          end else if (w_tmo_hit) begin
            r_rsp_en <= 1'b1;
            r_data   <= '0;
            r_error  <= 1'b1;
            r_state  <= FLUSH;
          end
        end
        RD_REQ: begin
          if (bus.axi_arready) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (bus.axi_rvalid) begin
            r_rready <= 1'b0;
            r_rsp_en <= 1'b1;
            r_data   <= bus.axi_rdata;
            r_error  <= (bus.axi_rresp != OKAY);
            r_state  <= IDLE;
          end else if (w_tmo_hit) begin
            r_rsp_en <= 1'b1;
            r_data   <= '0;
            r_error  <= 1'b1;
            r_state  <= FLUSH;
          end
        end
        FLUSH: begin
          // The timed-out response was already reported; swallow the late one silently.
          if ((r_bready && bus.axi_bvalid) || (r_rready && bus.axi_rvalid)) begin
            r_bready <= 1'b0;
            r_rready <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.response_enable = r_rsp_en;
  assign bus.data            = r_data;
  assign bus.error           = r_error;
  assign bus.axi_awaddr      = r_awaddr;
  assign bus.axi_awprot      = 3'b000;
  assign bus.axi_awvalid     = r_awvalid;
  assign bus.axi_wdata       = r_wdata;
  assign bus.axi_wstrb       = r_wstrb;
  assign bus.axi_wvalid      = r_wvalid;
  assign bus.axi_bready      = r_bready;
  assign bus.axi_araddr      = r_araddr;
  assign bus.axi_arprot      = 3'b000;
  assign bus.axi_arvalid     = r_arvalid;
  assign bus.axi_rready      = r_rready;

endmodule
